multu_unit: RTL and testbench

- Multi-cycle unsigned multiplier that responds to the MULTU request from the ALU control decoder in the EX stage.
- Holds the HI/LO architectural registers, which the EX result mux reads for MFHI/MFLO.
- Uses a radix-2 shift-add algorithm: one multiplier bit per cycle.
- Raises busy so the hazard unit can stall dependent MFHI/MFLO and further MULTU instructions.

---
 rtl/multu_unit_pkg.sv | 20 ++
 rtl/multu_unit_if.sv | 25 ++
 rtl/multu_step.sv | 25 ++
 rtl/multu_unit.sv | 96 +++++++++
 tb/tb_multu_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/multu_unit_pkg.sv
// Shared definitions for the MULTU unit: default sizes, FSM state
// encodings and the funct codes the ALU control decoder uses for
// MULTU/MFHI/MFLO.
package multu_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

endpackage

// File: rtl/multu_unit_if.sv
// Request/result bundle between the EX stage and the MULTU unit.
// The EX stage is the master; the multiplier is the slave.
interface multu_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op_a, op_b,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, hi_out, lo_out
  );

endinterface

// File: rtl/multu_step.sv
// One radix-2 shift-add iteration on the 2*WIDTH+1 bit accumulator.
// The top WIDTH+1 bits hold carry plus the upper half of the running
// product; the low WIDTH bits still hold the unconsumed multiplier bits.
module multu_step
  import multu_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH:0] p_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [2*WIDTH:0] p_o
);

  logic [WIDTH:0] top_sum;

  // Conditional add of the multiplicand, then logical shift right by one.
  always_comb begin
    top_sum = p_i[2*WIDTH:WIDTH];
    if (p_i[0]) begin
      top_sum = p_i[2*WIDTH:WIDTH] + {1'b0, m_i};
    end
    p_o = {1'b0, top_sum, p_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_unit.sv
// Multi-cycle unsigned multiplier holding the HI/LO registers.
// One multiplier bit is consumed per cycle; HI/LO change only on the
// final iteration so readers during RUN see the previous product.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | iterating, busy=1, WIDTH edges
// ST_DONE | HI/LO just committed, done=1, start accepted as in IDLE
module multu_unit
  import multu_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  multu_unit_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH:0]   p_step;
  logic               last_iter;

  multu_step #(.WIDTH(WIDTH)) u_step (
    .p_i (p_q),
    .m_i (m_q),
    .p_o (p_step)
  );

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          m_d     = bus.op_a;
          p_d     = {{(WIDTH+1){1'b0}}, bus.op_b};
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          hi_d    = p_step[2*WIDTH-1:WIDTH];
          lo_d    = p_step[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_multu_unit.sv
// Self-checking bench for multu_unit: directed corner cases plus random
// operands, checked against a plain 64-bit product model.
module tb_multu_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multu_unit_if #(.WIDTH(W)) bus ();

  multu_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] aa;
    logic [63:0] bb;
    aa = {32'b0, a};
    bb = {32'b0, b};
    return aa * bb;
  endfunction

  // Called on a falling edge; presents start for exactly one rising edge,
  // then scrambles the operands to show they are not resampled.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  // Follows one operation from the cycle after the start edge to its done
  // cycle; returns on the falling edge of the done cycle.
  task automatic await_done(input string tag, input logic [63:0] exp,
                            input logic [63:0] old, input int inj);
    int  nbusy    = 0;
    bit  got      = 0;
    bit  hold_ok  = 1;
    bit  injected = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (injected) bus.start = 1'b0;
      if (i == 0) check({tag, "_busy_rise"}, {63'b0, bus.busy}, 64'd1);
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.busy) nbusy++;
      if ({bus.hi_out, bus.lo_out} !== old) hold_ok = 0;
      if (inj != 0 && nbusy == inj && !injected) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd7;
        injected  = 1;
      end
    end
    check({tag, "_done_seen"}, {63'b0, got}, 64'd1);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
    check({tag, "_hold"}, {63'b0, hold_ok}, 64'd1);
    check({tag, "_hi"}, {32'b0, bus.hi_out}, {32'b0, exp[63:32]});
    check({tag, "_lo"}, {32'b0, bus.lo_out}, {32'b0, exp[31:0]});
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, {63'b0, bus.done}, 64'd0);
    check({tag, "_busy_low"}, {63'b0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] prev;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int ndone;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3 x 5
    issue(32'd3, 32'd5);
    await_done("m3x5", model(32'd3, 32'd5), 64'd0, 0);
    expect_idle("m3x5_after");

    // maximum operands exercise the accumulator carry bit
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    await_done("max", model(32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'd15, 0);
    check("max_const", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFE_0000_0001);
    expect_idle("max_after");

    // start pulsed mid-RUN is ignored
    issue(32'h0001_0000, 32'h0001_0000);
    await_done("ign", model(32'h0001_0000, 32'h0001_0000),
               64'hFFFF_FFFE_0000_0001, 10);
    expect_idle("ign_after");

    // zero operand still iterates fully; hold of prior product checked
    issue(32'd0, 32'h1234_5678);
    await_done("zero", 64'd0, 64'h0000_0001_0000_0000, 0);
    expect_idle("zero_after");

    // back-to-back: new start in the DONE cycle
    issue(32'd6, 32'd7);
    await_done("b2b1", model(32'd6, 32'd7), 64'd0, 0);
    issue(32'h8000_0000, 32'd2);
    await_done("b2b2", model(32'h8000_0000, 32'd2), 64'd42, 0);
    expect_idle("b2b_after");

    // asynchronous reset in the middle of an operation
    issue(32'd100, 32'd200);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {63'b0, bus.busy}, 64'd0);
    check("arst_done", {63'b0, bus.done}, 64'd0);
    check("arst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'd0);
    check("arst_hilo_kept", {bus.hi_out, bus.lo_out}, 64'd0);

    // random operands
    prev = 64'd0;
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k == 2) ra = '0;
      if (k == 3) rb = 32'hFFFF_FFFF;
      issue(ra, rb);
      await_done("rnd", model(ra, rb), prev, 0);
      prev = model(ra, rb);
      expect_idle("rnd_after");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
